// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard unit: the scoreboard
// entry layout, the register-file select code and the select-width helper.
package fwd_pkg;

    // Scoreboard rd field width; REG_AW of any instance must not exceed it.
    localparam int RD_W_MAX    = 8;
    localparam int SEL_REGFILE = 0;

    typedef struct packed {
        logic                valid;
        logic [RD_W_MAX-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } sb_entry_t;

    function automatic int sel_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request / EX-stage select bundle between the pipeline and the
// forwarding unit. master = pipeline side, slave = forwarding unit.
interface fwd_hazard_unit_if #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int SEL_W   = 2
);
    logic                             id_valid;
    logic [NUM_SRC-1:0][REG_AW-1:0]   id_rs;
    logic [NUM_SRC-1:0]               id_rs_used;
    logic [REG_AW-1:0]                id_rd;
    logic                             id_reg_write;
    logic                             id_mem_read;
    logic                             ex_flush;
    logic                             pipe_hold;
    logic [NUM_SRC-1:0][SEL_W-1:0]    fwd_sel;
    logic                             stall;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_mem_read,
               ex_flush, pipe_hold,
        input  fwd_sel, stall
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_mem_read,
               ex_flush, pipe_hold,
        output fwd_sel, stall
    );
endinterface

// File: rtl/fwd_match.sv
// Youngest-first priority matcher for one source operand against the tracked
// producers; yields the forward select and whether that producer is a late load.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int REG_AW     = 5,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = 2
) (
    input  sb_entry_t          sb_i [0:DEPTH-1],
    input  logic [REG_AW-1:0]  rs_i,
    input  logic               rs_used_i,
    output logic [SEL_W-1:0]   sel_o,
    output logic               hazard_o
);

    logic [DEPTH-1:0] hit;

    // x0 is hard-wired zero, so it is never treated as produced.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit[gi] = rs_used_i && sb_i[gi].valid && sb_i[gi].reg_write &&
                             (sb_i[gi].rd != '0) &&
                             (sb_i[gi].rd == RD_W_MAX'(rs_i));
        end
    endgenerate

    // Scan oldest to youngest so the youngest hit overwrites the result.
    always_comb begin
        sel_o    = SEL_W'(SEL_REGFILE);
        hazard_o = 1'b0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (hit[j]) begin
                sel_o    = SEL_W'(j + 1);
                hazard_o = sb_i[j].mem_read && ((j + 1) < LOAD_STAGE);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: shift-register scoreboard of in-flight
// destinations, registered EX forward selects and a combinational stall.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int  NUM_SRC    = 2,
    parameter int  DEPTH      = 2,
    parameter int  REG_AW     = 5,
    parameter int  LOAD_STAGE = 2,
    localparam int SEL_W      = sel_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    fwd_hazard_unit_if.slave bus
);

    sb_entry_t                      e_q [0:DEPTH];
    sb_entry_t                      e0_d;
    sb_entry_t                      match_view [0:DEPTH-1];
    logic [NUM_SRC-1:0][SEL_W-1:0]  cand_sel;
    logic [NUM_SRC-1:0][SEL_W-1:0]  fwd_sel_q;
    logic [NUM_SRC-1:0][SEL_W-1:0]  fwd_sel_d;
    logic [NUM_SRC-1:0]             src_hazard;
    logic                           stall_int;
    logic                           bubble;

    // The ID instruction lands one stage behind each entry, hence e[j] -> sel j+1;
    // the entry at DEPTH is already served by the write-through register file.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
            assign match_view[gi] = e_q[gi];
        end

        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_match #(
                .DEPTH      (DEPTH),
                .REG_AW     (REG_AW),
                .LOAD_STAGE (LOAD_STAGE),
                .SEL_W      (SEL_W)
            ) u_match (
                .sb_i      (match_view),
                .rs_i      (bus.id_rs[gi]),
                .rs_used_i (bus.id_rs_used[gi]),
                .sel_o     (cand_sel[gi]),
                .hazard_o  (src_hazard[gi])
            );
        end
    endgenerate

    assign stall_int = bus.id_valid && (|src_hazard) && !reset;
    assign bubble    = bus.ex_flush || stall_int;

    always_comb begin
        e0_d      = '0;
        fwd_sel_d = '0;
        if (!bubble) begin
            e0_d.valid     = bus.id_valid;
            e0_d.rd        = RD_W_MAX'(bus.id_rd);
            e0_d.reg_write = bus.id_reg_write;
            e0_d.mem_read  = bus.id_mem_read;
            if (bus.id_valid) begin
                fwd_sel_d = cand_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= DEPTH; k++) begin
                e_q[k] <= '0;
            end
            fwd_sel_q <= '0;
        end else if (!bus.pipe_hold) begin
            for (int k = 1; k <= DEPTH; k++) begin
                e_q[k] <= e_q[k-1];
            end
            e_q[0]    <= e0_d;
            fwd_sel_q <= fwd_sel_d;
        end
    end

    assign bus.fwd_sel = fwd_sel_q;
    assign bus.stall   = stall_int;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit at NUM_SRC=2, DEPTH=2, LOAD_STAGE=2:
// one ID instruction per call, stall checked before the edge, fwd_sel after it.
module tb_fwd_hazard_unit;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    fwd_hazard_unit_if #(.NUM_SRC(2), .REG_AW(5), .SEL_W(2)) bus ();

    fwd_hazard_unit #(
        .NUM_SRC    (2),
        .DEPTH      (2),
        .REG_AW     (5),
        .LOAD_STAGE (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one ID instruction with control inputs, check stall mid-cycle,
    // clock once, then check the selects now visible for EX.
    task automatic issue(input string tag, input logic v, input int rs0, input int rs1,
                         input logic [1:0] used, input int rd, input logic rw, input logic mr,
                         input logic fl, input logic hd, input logic rst,
                         input int xs, input int x0, input int x1);
        bus.id_valid     = v;
        bus.id_rs[0]     = 5'(rs0);
        bus.id_rs[1]     = 5'(rs1);
        bus.id_rs_used   = used;
        bus.id_rd        = 5'(rd);
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.ex_flush     = fl;
        bus.pipe_hold    = hd;
        reset            = rst;
        #2;
        chk_val({tag, ".stall"}, int'(bus.stall), xs);
        @(posedge clk);
        #1;
        chk_val({tag, ".sel0"}, int'(bus.fwd_sel[0]), x0);
        chk_val({tag, ".sel1"}, int'(bus.fwd_sel[1]), x1);
        $display("txn %-12s v=%0b rs=%0d,%0d used=%b rd=%0d fl=%0b hd=%0b rst=%0b -> sel=%0d,%0d",
                 tag, v, rs0, rs1, used, rd, fl, hd, rst, bus.fwd_sel[0], bus.fwd_sel[1]);
    endtask

    // Plain instruction with no flush/hold/reset.
    task automatic op(input string tag, input int rs0, input int rs1, input logic [1:0] used,
                      input int rd, input logic rw, input logic mr,
                      input int xs, input int x0, input int x1);
        issue(tag, 1'b1, rs0, rs1, used, rd, rw, mr, 1'b0, 1'b0, 1'b0, xs, x0, x1);
    endtask

    task automatic nop(input string tag);
        issue(tag, 1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        issue("reset", 1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);

        // EX/MEM forward
        op("add_x5", 1, 2, 2'b11, 5, 1, 0, 0, 0, 0);
        op("sub_x5x1", 5, 1, 2'b11, 6, 1, 0, 0, 1, 0);
        nop("nop_a"); nop("nop_b");

        // MEM/WB forward then register file
        op("add_x5b", 1, 2, 2'b11, 5, 1, 0, 0, 0, 0);
        nop("nop_c");
        op("or_x2x5", 2, 5, 2'b11, 7, 1, 0, 0, 0, 2);
        op("rd4_x5", 5, 5, 2'b11, 10, 1, 0, 0, 0, 0);
        nop("nop_d"); nop("nop_e");

        // Youngest producer wins
        op("addi_x5", 1, 0, 2'b01, 5, 1, 0, 0, 0, 0);
        op("add_x5c", 1, 2, 2'b11, 5, 1, 0, 0, 0, 0);
        op("rd_x5x3", 5, 3, 2'b11, 11, 1, 0, 0, 1, 0);
        nop("nop_f"); nop("nop_g");

        // Load-use: one bubble then MEM/WB forward
        op("lw_x7", 1, 0, 2'b01, 7, 1, 1, 0, 0, 0);
        op("add_x7_st", 7, 7, 2'b11, 8, 1, 0, 1, 0, 0);
        op("add_x7_go", 7, 7, 2'b11, 8, 1, 0, 0, 2, 2);
        nop("nop_h"); nop("nop_i");

        // x0 never matches, including a load to x0
        op("addi_x0", 1, 0, 2'b01, 0, 1, 0, 0, 0, 0);
        op("rd_x0", 0, 0, 2'b11, 12, 1, 0, 0, 0, 0);
        op("lw_x0", 1, 0, 2'b01, 0, 1, 1, 0, 0, 0);
        op("rd_x0_ld", 0, 0, 2'b11, 13, 1, 0, 0, 0, 0);
        nop("nop_j"); nop("nop_k");

        // Unused operands never forward or stall
        op("add_x9", 1, 2, 2'b11, 9, 1, 0, 0, 0, 0);
        op("nouse_x9", 9, 9, 2'b00, 13, 1, 0, 0, 0, 0);
        op("lw_x10", 1, 0, 2'b01, 10, 1, 1, 0, 0, 0);
        op("nouse_x10", 10, 10, 2'b00, 14, 1, 0, 0, 0, 0);
        op("use1_x10", 10, 10, 2'b10, 15, 1, 0, 0, 0, 2);
        nop("nop_l"); nop("nop_m");

        // Flush of the load in ID
        issue("lw_x7_fl", 1'b1, 1, 0, 2'b01, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        op("add_x7_nf", 7, 7, 2'b11, 8, 1, 0, 0, 0, 0);
        nop("nop_n"); nop("nop_o");

        // Flush coincident with stall: flush wins, no forward
        op("lw_x7_b", 1, 0, 2'b01, 7, 1, 1, 0, 0, 0);
        issue("add_fl_st", 1'b1, 7, 7, 2'b11, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0);
        op("add_x7_re", 7, 7, 2'b11, 8, 1, 0, 0, 2, 2);
        nop("nop_p"); nop("nop_q");

        // Hold: selects and scoreboard frozen for three cycles
        op("add_x5h", 1, 2, 2'b11, 5, 1, 0, 0, 0, 0);
        op("sub_x5h", 5, 1, 2'b11, 6, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            issue($sformatf("or_hold%0d", i), 1'b1, 2, 5, 2'b11, 7, 1'b1, 1'b0,
                  1'b0, 1'b1, 1'b0, 0, 1, 0);
        end
        op("or_rel", 2, 5, 2'b11, 7, 1, 0, 0, 0, 2);
        nop("nop_r"); nop("nop_s");

        // Hold during a load-use stall keeps stall asserted
        op("lw_x7_h", 1, 0, 2'b01, 7, 1, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            issue($sformatf("ld_hold%0d", i), 1'b1, 7, 7, 2'b11, 8, 1'b1, 1'b0,
                  1'b0, 1'b1, 1'b0, 1, 0, 0);
        end
        op("ld_rel_st", 7, 7, 2'b11, 8, 1, 0, 1, 0, 0);
        op("ld_rel_go", 7, 7, 2'b11, 8, 1, 0, 0, 2, 2);
        nop("nop_t"); nop("nop_u");

        // Reset mid-stream discards in-flight tags
        op("add_x5r", 1, 2, 2'b11, 5, 1, 0, 0, 0, 0);
        issue("rd_x5_rst", 1'b1, 5, 5, 2'b11, 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        op("rd_x5_post", 5, 5, 2'b11, 9, 1, 0, 0, 0, 0);
        op("lw_x7_r", 1, 0, 2'b01, 7, 1, 1, 0, 0, 0);
        issue("ld_rst", 1'b1, 7, 7, 2'b11, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        op("ld_post", 7, 7, 2'b11, 8, 1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
